// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Shared types and oversampling constants for the UART receiver.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 8;
    localparam int unsigned MID_SAMPLE = 4;

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module   : uart_rx
// Brief    : 8x-oversampled UART receiver with parity, framing and overrun flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 bclkx8,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam logic [2:0] C_LAST_TICK = 3'(OVERSAMPLE - 1);
    localparam logic [2:0] C_MID_TICK  = 3'(MID_SAMPLE - 1);
    localparam logic [3:0] C_LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       C_ODD       = (PARITY_ODD != 0);

    // Front end: synchronizer, edge history and tick detector
    logic       rx_meta_q, rx_meta_d;
    logic       rx_s_q,    rx_s_d;
    logic       rx_prev_q, rx_prev_d;
    logic       bclk_q,    bclk_d;
    logic [1:0] fill_q,    fill_d;
    logic       armed_q,   armed_d;

    // Frame FSM
    rx_state_t              state_q,    state_d;
    logic [2:0]             tick_cnt_q, tick_cnt_d;
    logic [3:0]             bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic                   par_bad_q,  par_bad_d;

    // Held frame
    logic [DATA_BITS-1:0]   rx_data_q,  rx_data_d;
    logic                   valid_q,    valid_d;
    logic                   ferr_q,     ferr_d;
    logic                   perr_q,     perr_d;
    logic                   ovr_q,      ovr_d;

    logic w_tick;
    logic w_fall;
    logic w_mid_tick;
    logic w_last_tick;
    logic w_frame_done;
    logic w_stop_bad;

    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
        bclk_d    = bclkx8;
        fill_d    = {fill_q[0], 1'b1};
        // A line already low when reset releases must not look like a start bit
        armed_d   = armed_q | (fill_q[1] & rx_s_q);
    end

    assign w_tick      = bclkx8 & ~bclk_q;
    assign w_fall      = armed_q & rx_prev_q & ~rx_s_q;
    assign w_mid_tick  = w_tick && (tick_cnt_q == C_MID_TICK);
    assign w_last_tick = w_tick && (tick_cnt_q == C_LAST_TICK);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            bclk_q    <= 1'b0;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
            bclk_q    <= bclk_d;
            fill_q    <= fill_d;
            armed_q   <= armed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        w_frame_done = 1'b0;
        w_stop_bad   = 1'b0;

        if (state_q != IDLE && w_tick) begin
            tick_cnt_d = tick_cnt_q + 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (w_fall) begin
                    state_d    = START;
                    tick_cnt_d = 3'd0;
                end
            end
            START: begin
                if (w_mid_tick) begin
                    tick_cnt_d = 3'd0;
                    bit_cnt_d  = 4'd0;
                    par_bad_d  = 1'b0;
                    state_d    = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_last_tick) begin
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == C_LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_last_tick) begin
                    par_bad_d = rx_s_q ^ (^shift_q) ^ C_ODD;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (w_last_tick) begin
                    w_frame_done = 1'b1;
                    w_stop_bad   = ~rx_s_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= 3'd0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
        end
    end

    // A completing frame may replace the held one only if it is free or being acked now
    always_comb begin
        rx_data_d = rx_data_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        perr_d    = perr_q;
        ovr_d     = ovr_q;

        if (w_frame_done) begin
            if (!valid_q || rx_ack) begin
                rx_data_d = shift_q;
                ferr_d    = w_stop_bad;
                perr_d    = par_bad_q;
                valid_d   = 1'b1;
                ovr_d     = 1'b0;
            end else begin
                ovr_d     = 1'b1;
            end
        end else if (rx_ack && valid_q) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_data_q <= rx_data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = valid_q;
    assign framing_err = ferr_q;
    assign parity_err  = perr_q;
    assign overrun     = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx (8N1 instance and 8O1 instance).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

    localparam int BIT_CYC = 32;   // 8 ticks of a 4-cycle bclkx8

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       bclkx8  = 1'b0;
    logic       rx      = 1'b1;
    logic       rx_p    = 1'b1;
    logic       rx_ack  = 1'b0;
    logic       rx_ack_p = 1'b0;

    logic [7:0] rx_data,  rx_data_p;
    logic       rx_valid, rx_valid_p;
    logic       framing_err, framing_err_p;
    logic       parity_err,  parity_err_p;
    logic       overrun,     overrun_p;

    int checks = 0;
    int errors = 0;

    // Frame-level model of the held-frame register, one slot per instance
    logic       m_valid [2];
    logic [7:0] m_data  [2];
    logic       m_ferr  [2];
    logic       m_perr  [2];
    logic       m_ovr   [2];

    uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .bclkx8      (bclkx8),
        .rx          (rx),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .framing_err (framing_err),
        .parity_err  (parity_err),
        .overrun     (overrun)
    );

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_p (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .bclkx8      (bclkx8),
        .rx          (rx_p),
        .rx_ack      (rx_ack_p),
        .rx_data     (rx_data_p),
        .rx_valid    (rx_valid_p),
        .framing_err (framing_err_p),
        .parity_err  (parity_err_p),
        .overrun     (overrun_p)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        forever begin
            repeat (2) @(posedge sys_clk);
            #1 bclkx8 = ~bclkx8;
        end
    end

    function automatic logic [11:0] obs(input int s);
        if (s == 1) return {rx_valid_p, rx_data_p, framing_err_p, parity_err_p, overrun_p};
        return {rx_valid, rx_data, framing_err, parity_err, overrun};
    endfunction

    function automatic logic [11:0] expv(input int s);
        return {m_valid[s], m_data[s], m_ferr[s], m_perr[s], m_ovr[s]};
    endfunction

    task automatic model_clear_all();
        for (int s = 0; s < 2; s++) begin
            m_valid[s] = 1'b0; m_data[s] = 8'h00;
            m_ferr[s]  = 1'b0; m_perr[s] = 1'b0; m_ovr[s] = 1'b0;
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic set_line(input int s, input logic b);
        if (s == 1) rx_p = b;
        else        rx   = b;
    endtask

    task automatic send_bits(input int s, input logic [7:0] d, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            set_line(s, d[i]);
            hold(BIT_CYC);
        end
    endtask

    // Drive one whole frame, then let the model absorb it
    task automatic send_frame(input int s, input logic [7:0] d, input logic pbit, input logic stop);
        set_line(s, 1'b0);
        hold(BIT_CYC);
        send_bits(s, d, 0, 7);
        if (s == 1) begin
            set_line(s, pbit);
            hold(BIT_CYC);
        end
        set_line(s, stop);
        hold(BIT_CYC);
        set_line(s, 1'b1);
        hold(stop ? 8 : BIT_CYC);
        if (!m_valid[s]) begin
            m_valid[s] = 1'b1;
            m_data[s]  = d;
            m_ferr[s]  = ~stop;
            m_perr[s]  = (s == 1) && (pbit != ~(^d));
            m_ovr[s]   = 1'b0;
        end else begin
            m_ovr[s] = 1'b1;
        end
    endtask

    task automatic do_ack(input int s);
        if (s == 1) rx_ack_p = 1'b1;
        else        rx_ack   = 1'b1;
        hold(1);
        rx_ack_p = 1'b0;
        rx_ack   = 1'b0;
        if (m_valid[s]) begin
            m_valid[s] = 1'b0; m_ferr[s] = 1'b0; m_perr[s] = 1'b0; m_ovr[s] = 1'b0;
        end
        hold(2);
    endtask

    task automatic test_reset();
        model_clear_all();
        #23;
        checks++;
        if (obs(0) !== 12'h000) begin
            errors++; $display("FAIL reset_8n1: got %h expected %h", obs(0), 12'h000);
        end
        checks++;
        if (obs(1) !== 12'h000) begin
            errors++; $display("FAIL reset_8o1: got %h expected %h", obs(1), 12'h000);
        end
        hold(1);
        rst_n = 1'b1;
        hold(16);
    endtask

    task automatic test_basic();
        send_frame(0, 8'h55, 1'b0, 1'b1);
        checks++;
        if (obs(0) !== {1'b1, 8'h55, 3'b000} || obs(0) !== expv(0)) begin
            errors++; $display("FAIL basic_55: got %h expected %h", obs(0), expv(0));
        end
        do_ack(0);
        checks++;
        if (obs(0) !== expv(0)) begin
            errors++; $display("FAIL basic_ack: got %h expected %h", obs(0), expv(0));
        end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        hold(8);
        rx = 1'b1;
        hold(4 * BIT_CYC);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++; $display("FAIL glitch_valid: got %b expected %b", rx_valid, 1'b0);
        end
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        checks++;
        if (obs(0) !== expv(0)) begin
            errors++; $display("FAIL glitch_next: got %h expected %h", obs(0), expv(0));
        end
        do_ack(0);
    endtask

    task automatic test_framing();
        send_frame(0, 8'hA3, 1'b0, 1'b0);
        checks++;
        if (obs(0) !== {1'b1, 8'hA3, 3'b100} || obs(0) !== expv(0)) begin
            errors++; $display("FAIL framing_a3: got %h expected %h", obs(0), expv(0));
        end
        do_ack(0);
        send_frame(0, 8'h01, 1'b0, 1'b1);
        checks++;
        if (obs(0) !== {1'b1, 8'h01, 3'b000}) begin
            errors++; $display("FAIL framing_next: got %h expected %h", obs(0), {1'b1, 8'h01, 3'b000});
        end
        do_ack(0);
    endtask

    task automatic test_parity();
        send_frame(1, 8'h0F, 1'b0, 1'b1);
        checks++;
        if (obs(1) !== {1'b1, 8'h0F, 3'b010} || obs(1) !== expv(1)) begin
            errors++; $display("FAIL parity_bad: got %h expected %h", obs(1), expv(1));
        end
        do_ack(1);
        send_frame(1, 8'h0F, 1'b1, 1'b1);
        checks++;
        if (obs(1) !== {1'b1, 8'h0F, 3'b000} || obs(1) !== expv(1)) begin
            errors++; $display("FAIL parity_good: got %h expected %h", obs(1), expv(1));
        end
        do_ack(1);
    endtask

    task automatic test_back_to_back();
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        checks++;
        if (obs(0) !== {1'b1, 8'h11, 3'b001} || obs(0) !== expv(0)) begin
            errors++; $display("FAIL overrun_hold: got %h expected %h", obs(0), expv(0));
        end
        do_ack(0);
        checks++;
        if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_ack: got %b%b expected 00", rx_valid, overrun);
        end
        do_ack(0);
        checks++;
        if (obs(0) !== expv(0)) begin
            errors++; $display("FAIL idle_ack: got %h expected %h", obs(0), expv(0));
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(0, 8'h9E, 1'b0, 1'b0);
        rx = 1'b0;
        hold(BIT_CYC);
        send_bits(0, 8'h07, 0, 2);
        rx = 1'b0;
        hold(BIT_CYC / 2);
        rst_n = 1'b0;
        #2;
        model_clear_all();
        checks++;
        if (obs(0) !== 12'h000) begin
            errors++; $display("FAIL midreset_clear: got %h expected %h", obs(0), 12'h000);
        end
        hold(3);
        rst_n = 1'b1;
        hold(BIT_CYC / 2 - 4);
        send_bits(0, 8'h07, 4, 7);
        rx = 1'b1;
        hold(3 * BIT_CYC);
        checks++;
        if (obs(0) !== 12'h000) begin
            errors++; $display("FAIL midreset_quiet: got %h expected %h", obs(0), 12'h000);
        end
        send_frame(0, 8'hC4, 1'b0, 1'b1);
        checks++;
        if (obs(0) !== {1'b1, 8'hC4, 3'b000}) begin
            errors++; $display("FAIL midreset_c4: got %h expected %h", obs(0), {1'b1, 8'hC4, 3'b000});
        end
        do_ack(0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int         s;
            logic [7:0] d;
            logic       pbit;
            logic       stop;
            s    = int'($urandom_range(0, 1));
            d    = 8'($urandom);
            pbit = 1'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(s, d, pbit, stop);
            checks++;
            if (obs(s) !== expv(s)) begin
                errors++; $display("FAIL random_%0d_inst%0d: got %h expected %h", n, s, obs(s), expv(s));
            end
            if ($urandom_range(0, 2) != 0) begin
                do_ack(s);
                checks++;
                if (obs(s) !== expv(s)) begin
                    errors++; $display("FAIL random_ack_%0d: got %h expected %h", n, obs(s), expv(s));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_parity();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, shall set the number of data bits per frame (legal 5..8).
REQ-002 Parameter PARITY_EN, default 0, shall add one parity bit after the data bits when 1.
REQ-003 Parameter PARITY_ODD, default 0, shall select odd parity when 1 and even parity when 0; it is ignored when PARITY_EN=0.
REQ-004 sys_clk  input  1  Single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  Asynchronous, active-low reset.
REQ-006 bclkx8  input  1  8x-baud square wave from the baud generator, synchronous to sys_clk.
REQ-007 rx  input  1  Asynchronous serial line; idles high.
REQ-008 rx_ack  input  1  Consumer acknowledge of the held frame.
REQ-009 rx_data  output  DATA_BITS  Last received data, LSB first on the line.
REQ-010 rx_valid  output  1  Held high while rx_data is unacknowledged.
REQ-011 framing_err  output  1  Stop bit of the held frame sampled low.
REQ-012 parity_err  output  1  Parity mismatch on the held frame.
REQ-013 overrun  output  1  A frame completed while rx_valid=1 and rx_ack=0.

Function
REQ-014 rx shall pass through a 2-FF synchronizer before use; rx_s denotes the synchronized value.
REQ-015 The tick shall be a one-sys_clk-cycle pulse generated on each rising edge of bclkx8, detected against a registered copy of bclkx8.
REQ-016 The FSM shall have exactly five states: IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: on a 1->0 transition of rx_s, the FSM shall enter START with tick counter = 0; a line held low shall not retrigger.
REQ-018 START: the counter shall increment on each tick; on the 4th tick (mid-bit), rx_s=0 shall lead to DATA, and rx_s=1 shall lead to IDLE (glitch reject).
REQ-019 DATA: a bit shall be sampled on every 8th tick, LSB first, into a shift register; after DATA_BITS samples the FSM shall go to PARITY if PARITY_EN=1, else to STOP.
REQ-020 PARITY: the FSM shall sample on the 8th tick and compare against the XOR of the data bits (inverted when PARITY_ODD=1), then go to STOP.
REQ-021 STOP: the FSM shall sample on the 8th tick and record framing_err = ~rx_s, complete the frame in that same cycle, and go to IDLE.
REQ-022 Frame completion with rx_valid=0, or with rx_ack=1 in that cycle, shall on the next edge load rx_data, framing_err and parity_err, and set rx_valid=1, overrun=0.
REQ-023 Frame completion with rx_valid=1 and rx_ack=0 shall leave rx_data, framing_err and parity_err unchanged and set overrun=1.
REQ-024 rx_ack=1 with rx_valid=1 and no completion in that cycle shall clear rx_valid, framing_err, parity_err and overrun on the next edge.
REQ-025 rx_ack while rx_valid=0 shall have no effect.
REQ-026 Ticks shall be ignored in IDLE; sys_clk cycles without a tick shall not change the counter.
REQ-027 Latency from the STOP-sample tick to rx_valid high shall be exactly one sys_clk cycle.

Reset
REQ-028 rst_n low shall asynchronously force the FSM to IDLE and clear the counters and shift register.
REQ-029 rst_n low shall asynchronously set rx_data=0, rx_valid=0, framing_err=0, parity_err=0 and overrun=0.
REQ-030 The synchronizer flops and the bclkx8 edge register shall reset to 1 and 0 respectively.
REQ-031 A reset asserted mid-frame shall discard the frame; after release, reception shall resume only on a fresh falling edge.

Structure
REQ-032 Package uart_pkg shall hold the rx_state_t enum, OVERSAMPLE=8 and MID_SAMPLE=4.
REQ-033 The block shall be a single module with no sub-modules; the synchronizer and tick edge detector shall be inline.

Verification
REQ-034 Frame 0x55, 8N1, with 8 ticks per bit shall produce rx_data=0x55, rx_valid=1 and all error flags 0 one cycle after the stop sample.
REQ-035 A rx low pulse of 2 ticks then high shall return the FSM to IDLE with rx_valid remaining 0.
REQ-036 Frame 0xA3 sent with stop bit 0 shall produce rx_data=0xA3 and framing_err=1; an immediate second 0x01 frame shall be received correctly after rx returns high and falls again.
REQ-037 With PARITY_EN=1 and PARITY_ODD=1, 0x0F sent with parity bit 0 shall produce parity_err=1; the same byte sent with parity bit 1 shall produce parity_err=0.
REQ-038 Frames 0x11 then 0x22 sent with no rx_ack shall produce rx_data=0x11 and overrun=1; a following rx_ack shall clear rx_valid and overrun.
REQ-039 rst_n pulsed low during data bit 3 of a frame shall clear all outputs with rx_valid staying 0, and a following 0xC4 frame shall be received correctly.
